cv32e40p_scnn_fire: RTL and testbench
=====================================

# cv32e40p_scnn_fire

Integrate-and-fire stage that consumes the 8×16 signed accumulator array built by the SCNN spike-gated multiply-accumulate stage. It turns the array back into packed 8-timestep spike trains in the same bit format that stage takes as its spike input. Per start, it integrates the accumulators into 16 persistent membrane potentials, fires against a programmable threshold with soft reset, and streams four 32-bit spike words (one per filter) over a valid/ready interface. It sits between the accumulator array and the next layer's spike buffer or register writeback.

## Interface
Parameters:
- ACC_W, 16, accumulator and membrane width (signed).
- T_STEPS, 8, timesteps per spike train (fixed at 8; spike byte width).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request to snapshot M_Cache_i and threshold_i and begin; honoured only in IDLE.
- vmem_clr_i  in  1  zero all 16 membranes; honoured only in IDLE.
- M_Cache_i  in  [7:0][15:0]×ACC_W signed  accumulators, index [t][j], t = timestep, j = 4·f + p (filter f, position p).
- threshold_i  in  ACC_W signed  firing threshold; values < 1 are treated as 1.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- spike_valid_o  out  1  spike word valid.
- spike_ready_i  in  1  downstream accept.
- spike_o  out  32  spike word for filter f; spike_o[8p+t] is the spike of position p at timestep t.
- spike_filt_o  out  2  filter index f of the current spike_o.
- done_o  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, CALC, SEND, DONE.
- IDLE, vmem_clr_i=1: all vmem[j] are set to 0. If start_i is also high in the same cycle, the clear applies first and the run uses zeroed membranes.
- IDLE, start_i=1: latch a full copy of M_Cache_i and the clamped threshold, set f=0, t=0, and go to CALC.
- CALC (8 cycles per filter): in cycle t, four lanes p=0..3 process j=4f+p.
  - sum = vmem[j] + cache[t][j], computed at 17 bits.
  - If sum ≥ thr: set spike bit [8p+t], and vmem[j] = sat16(sum − thr).
  - Otherwise: vmem[j] = sat16(sum).
  - sat16 clamps to [−32768, 32767].
  - After t=7, go to SEND with the completed word.
- SEND: spike_valid_o=1. spike_o and spike_filt_o are held stable until spike_ready_i. On the handshake: if f<3, set f=f+1, t=0, clear the word, and go to CALC. If f=3, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Membranes persist across runs until vmem_clr_i or rst.
- start_i and vmem_clr_i are ignored outside IDLE. Input changes after the snapshot have no effect.

## Timing
- Reset values:
  - state IDLE; all vmem 0.
  - busy_o, spike_valid_o, done_o = 0.
  - spike_o = 0, spike_filt_o = 0.
- Start accepted at edge 0. CALC occupies cycles 1–8. First spike_valid_o is asserted in cycle 9.
- With spike_ready_i held high, each word costs 9 cycles (8 CALC + 1 SEND), so done_o is in cycle 37 and IDLE resumes in cycle 38.
- Backpressure stalls in SEND only. No CALC progress occurs while a word is pending.
- rst in any state aborts the run immediately, clears the membranes, and deasserts valid with no partial done_o.
- spike_valid_o never depends combinationally on spike_ready_i.

## Test plan
- Reset: assert rst during SEND → next cycle spike_valid_o=0, busy_o=0, spike_o=0; a subsequent run from all-10 inputs matches the zero-membrane result.
- Basic fire: vmem cleared, all cache entries = 10, threshold_i = 25, ready held high → four words 0x94949494 with spike_filt_o 0,1,2,3; first valid in cycle 9; done_o in cycle 37; all vmem = 5.
- Persistence: repeat the same start without a clear → words 0x52525252; all vmem = 10.
- Backpressure: hold ready low for 5 cycles on the first word → spike_o and spike_filt_o stable and valid high throughout; done_o delayed by exactly 5 cycles.
- Saturation / clamp:
  - All entries −32768, threshold_i = 100 → words 0x00000000, vmem = −32768.
  - After clear, all entries 0x7FFF, threshold_i = 0 (clamped to 1) → words 0xFFFFFFFF.
- Ignored controls: start_i and vmem_clr_i pulsed mid-CALC → no restart and no membrane change; the result is identical to an undisturbed run.

Source files
------------

// File: rtl/cv32e40p_scnn_fire_if.sv
// Spike-word stream between the integrate-and-fire stage and its consumer.
// The producer drives the word, its filter index and valid; the consumer drives ready.
interface cv32e40p_scnn_fire_if;
    logic        spike_valid_o;
    logic        spike_ready_i;
    logic [31:0] spike_o;
    logic [1:0]  spike_filt_o;

    modport master (
        output spike_valid_o,
        output spike_o,
        output spike_filt_o,
        input  spike_ready_i
    );

    modport slave (
        input  spike_valid_o,
        input  spike_o,
        input  spike_filt_o,
        output spike_ready_i
    );
endinterface

// File: rtl/cv32e40p_scnn_fire.sv
// Integrate-and-fire stage: folds an 8x16 accumulator snapshot into 16 persistent
// membranes, fires against a clamped threshold with soft reset, and streams one
// packed 8-timestep spike word per filter (4 words) over a valid/ready channel.
module cv32e40p_scnn_fire #(
    parameter int ACC_W   = 16,
    parameter int T_STEPS = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              vmem_clr_i,
    input  logic [T_STEPS-1:0][15:0][ACC_W-1:0] M_Cache_i,
    input  logic [ACC_W-1:0]                  threshold_i,
    output logic                              busy_o,
    output logic                              done_o,
    cv32e40p_scnn_fire_if.master              bus
);

    typedef enum logic [1:0] {IDLE, CALC, SEND, DONE} state_t;

    state_t                              state_r;
    logic [T_STEPS-1:0][15:0][ACC_W-1:0] cache_r;
    logic [15:0][ACC_W-1:0]              vmem_r;
    logic [ACC_W-1:0]                    thr_r;
    logic [1:0]                          f_r;
    logic [2:0]                          t_r;
    logic [31:0]                         word_r;
    logic                                valid_r;
    logic                                busy_r;
    logic                                done_r;

    logic [ACC_W-1:0]                    thr_clamp_s;
    logic [3:0][ACC_W-1:0]               lane_vmem_s;
    logic [3:0]                          lane_fire_s;

    // Clamp a 17-bit intermediate back into the signed ACC_W range.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
        if (v[ACC_W] != v[ACC_W-1]) begin
            if (v[ACC_W]) begin
                return {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                return {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            return v[ACC_W-1:0];
        end
    endfunction

    // One lane step: returns {fire, next membrane}. The sum is formed at ACC_W+1 bits
    // so neither the compare nor the soft-reset subtraction can wrap.
    function automatic logic [ACC_W:0] fire_step(input logic [ACC_W-1:0] vm,
                                                 input logic [ACC_W-1:0] c,
                                                 input logic [ACC_W-1:0] thr);
        logic signed [ACC_W:0] sum_v;
        logic signed [ACC_W:0] thr_v;
        logic signed [ACC_W:0] diff_v;
        sum_v  = $signed({vm[ACC_W-1], vm}) + $signed({c[ACC_W-1], c});
        thr_v  = $signed({thr[ACC_W-1], thr});
        diff_v = sum_v - thr_v;
        if (sum_v >= thr_v) begin
            return {1'b1, sat_acc(diff_v)};
        end else begin
            return {1'b0, sat_acc(sum_v)};
        end
    endfunction

    // Thresholds below 1 (zero or negative) behave as 1.
    always_comb begin
        if (threshold_i[ACC_W-1] || (threshold_i == {ACC_W{1'b0}})) begin
            thr_clamp_s = {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            thr_clamp_s = threshold_i;
        end
    end

    // Four parallel lanes evaluate positions p=0..3 of the current filter at timestep t.
    always_comb begin
        lane_vmem_s = '0;
        lane_fire_s = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            logic [ACC_W:0] res_v;
            res_v = fire_step(vmem_r[{f_r, 2'(p)}], cache_r[t_r][{f_r, 2'(p)}], thr_r);
            lane_fire_s[p] = res_v[ACC_W];
            lane_vmem_s[p] = res_v[ACC_W-1:0];
        end
    end

    // Control FSM with membrane, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cache_r <= '0;
            vmem_r  <= '0;
            thr_r   <= '0;
            f_r     <= 2'd0;
            t_r     <= 3'd0;
            word_r  <= 32'h0000_0000;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (vmem_clr_i) begin
                        vmem_r <= '0;
                    end
                    if (start_i) begin
                        cache_r <= M_Cache_i;
                        thr_r   <= thr_clamp_s;
                        f_r     <= 2'd0;
                        t_r     <= 3'd0;
                        word_r  <= 32'h0000_0000;
                        busy_r  <= 1'b1;
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    for (int p = 0; p < 4; p++) begin
                        vmem_r[{f_r, 2'(p)}] <= lane_vmem_s[p];
                        word_r[{2'(p), t_r}] <= lane_fire_s[p];
                    end
                    t_r <= t_r + 3'd1;
                    if (t_r == 3'd7) begin
                        valid_r <= 1'b1;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (bus.spike_ready_i) begin
                        valid_r <= 1'b0;
                        if (f_r == 2'd3) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            f_r     <= f_r + 2'd1;
                            t_r     <= 3'd0;
                            word_r  <= 32'h0000_0000;
                            state_r <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.spike_valid_o = valid_r;
    assign bus.spike_o       = word_r;
    assign bus.spike_filt_o  = f_r;
    assign busy_o            = busy_r;
    assign done_o            = done_r;

endmodule

// File: tb/tb_cv32e40p_scnn_fire.sv
// Directed + randomized bench for the integrate-and-fire stage, checked against an
// integer reference model of the membrane/threshold rules.
module tb_cv32e40p_scnn_fire;

    logic                     clk;
    logic                     rst;
    logic                     start_i;
    logic                     vmem_clr_i;
    logic [7:0][15:0][15:0]   M_Cache_i;
    logic [15:0]              threshold_i;
    logic                     busy_o;
    logic                     done_o;

    cv32e40p_scnn_fire_if bus ();

    cv32e40p_scnn_fire #(.ACC_W(16), .T_STEPS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .vmem_clr_i  (vmem_clr_i),
        .M_Cache_i   (M_Cache_i),
        .threshold_i (threshold_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_vmem [16];
    int          m_cache [8][16];
    int          thr_cfg;
    logic [31:0] exp_w [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integrate every (t, j), fire when the sum reaches the threshold,
    // subtract on fire, saturate to 16-bit signed.
    function automatic void model_run();
        int thr;
        int s;
        thr = 32'($signed(thr_cfg[15:0]));
        if (thr < 1) thr = 1;
        for (int f = 0; f < 4; f++) begin
            exp_w[f] = 32'h0;
            for (int t = 0; t < 8; t++) begin
                for (int p = 0; p < 4; p++) begin
                    s = m_vmem[4*f+p] + m_cache[t][4*f+p];
                    if (s >= thr) begin
                        exp_w[f][8*p+t] = 1'b1;
                        s = s - thr;
                    end
                    if (s > 32767)  s = 32767;
                    if (s < -32768) s = -32768;
                    m_vmem[4*f+p] = s;
                end
            end
        end
    endfunction

    task automatic fill(input int v);
        for (int t = 0; t < 8; t++)
            for (int j = 0; j < 16; j++) m_cache[t][j] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int t = 0; t < 8; t++)
            for (int j = 0; j < 16; j++) m_cache[t][j] = lo + int'($urandom_range(hi - lo));
    endtask

    task automatic drive_inputs();
        for (int t = 0; t < 8; t++)
            for (int j = 0; j < 16; j++) M_Cache_i[t][j] = m_cache[t][j][15:0];
        threshold_i = thr_cfg[15:0];
    endtask

    task automatic clear_vmem();
        vmem_clr_i = 1'b1;
        tick();
        vmem_clr_i = 1'b0;
        for (int j = 0; j < 16; j++) m_vmem[j] = 0;
    endtask

    task automatic check_vmem(input string tag);
        for (int j = 0; j < 16; j++)
            check($sformatf("%s vmem[%0d]", tag, j), {16'h0, dut.vmem_r[j]}, {16'h0, m_vmem[j][15:0]});
    endtask

    // One full run: optional clear-with-start, optional stall on the first word,
    // optional disturbance of controls and inputs during CALC.
    task automatic run(input string tag, input int stall, input bit disturb, input bit clr);
        int cyc;
        int w;
        int stalled;
        int first_v;
        int done_c;
        if (clr) for (int j = 0; j < 16; j++) m_vmem[j] = 0;
        model_run();
        drive_inputs();
        vmem_clr_i    = clr;
        start_i       = 1'b1;
        bus.spike_ready_i = 1'b1;
        tick();
        start_i    = 1'b0;
        vmem_clr_i = 1'b0;
        cyc = 1; w = 0; stalled = 0; first_v = -1; done_c = -1;
        while (done_c < 0 && cyc < 300) begin
            if (cyc == 1) check({tag, " busy after start"}, {31'h0, busy_o}, 32'h1);
            if (disturb && cyc == 3) begin
                start_i    = 1'b1;
                vmem_clr_i = 1'b1;
                for (int t = 0; t < 8; t++)
                    for (int j = 0; j < 16; j++) M_Cache_i[t][j] = 16'($urandom);
                threshold_i = 16'($urandom);
            end
            if (disturb && cyc == 5) begin
                start_i    = 1'b0;
                vmem_clr_i = 1'b0;
            end
            if (bus.spike_valid_o) begin
                if (first_v < 0) first_v = cyc;
                check($sformatf("%s word%0d", tag, w), bus.spike_o, (w < 4) ? exp_w[w] : 32'hDEAD_BEEF);
                check($sformatf("%s filt%0d", tag, w), {30'h0, bus.spike_filt_o}, 32'(w));
                if (w == 0 && stalled < stall) begin
                    bus.spike_ready_i = 1'b0;
                    stalled++;
                end else begin
                    bus.spike_ready_i = 1'b1;
                    w++;
                end
            end else begin
                bus.spike_ready_i = 1'b1;
            end
            if (done_o) begin
                done_c = cyc;
            end else begin
                tick();
                cyc++;
            end
        end
        check({tag, " first valid cycle"}, 32'(first_v), 32'd9);
        check({tag, " done cycle"}, 32'(done_c), 32'(37 + stall));
        check({tag, " words sent"}, 32'(w), 32'd4);
        tick();
        check({tag, " busy after done"}, {31'h0, busy_o}, 32'h0);
        check({tag, " done pulse width"}, {31'h0, done_o}, 32'h0);
        check({tag, " valid after done"}, {31'h0, bus.spike_valid_o}, 32'h0);
        check_vmem(tag);
    endtask

    initial begin
        int waitc;
        rst = 1'b1; start_i = 1'b0; vmem_clr_i = 1'b0;
        M_Cache_i = '0; threshold_i = 16'h0; bus.spike_ready_i = 1'b1;
        for (int j = 0; j < 16; j++) m_vmem[j] = 0;
        tick(); tick();
        rst = 1'b0;
        check("reset valid", {31'h0, bus.spike_valid_o}, 32'h0);
        check("reset busy",  {31'h0, busy_o}, 32'h0);
        check("reset done",  {31'h0, done_o}, 32'h0);
        check("reset spike", bus.spike_o, 32'h0);
        check("reset filt",  {30'h0, bus.spike_filt_o}, 32'h0);
        check_vmem("reset");

        // Basic fire, then persistence without clearing.
        clear_vmem();
        fill(10); thr_cfg = 25;
        run("basic", 0, 1'b0, 1'b0);
        check("basic literal", exp_w[0], 32'h9494_9494);
        run("persist", 0, 1'b0, 1'b0);
        check("persist literal", exp_w[3], 32'h5252_5252);

        // Backpressure on the first word.
        clear_vmem();
        fill(10); thr_cfg = 25;
        run("stall", 5, 1'b0, 1'b0);

        // Negative saturation, then clamp of a zero threshold.
        clear_vmem();
        fill(-32768); thr_cfg = 100;
        run("negsat", 0, 1'b0, 1'b0);
        clear_vmem();
        fill(32767); thr_cfg = 0;
        run("possat", 0, 1'b0, 1'b0);

        // Controls and inputs toggled during CALC must have no effect.
        clear_vmem();
        fill_rand(-60, 120); thr_cfg = 90;
        run("ignored", 0, 1'b1, 1'b0);

        // Random runs: persistent membranes, occasional clear-with-start, negative thresholds.
        for (int r = 0; r < 4; r++) begin
            fill_rand(-500, 900);
            thr_cfg = (r == 2) ? -7 : 1 + int'($urandom_range(1500));
            run($sformatf("rand%0d", r), int'($urandom_range(3)), 1'b0, r[0]);
        end

        // Reset while a word is pending, then a fresh run from zeroed membranes.
        fill(10); thr_cfg = 25;
        drive_inputs();
        bus.spike_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        waitc = 0;
        while (!bus.spike_valid_o && waitc < 40) begin
            tick();
            waitc++;
        end
        check("rst wait for valid", {31'h0, bus.spike_valid_o}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 16; j++) m_vmem[j] = 0;
        check("rst-send valid", {31'h0, bus.spike_valid_o}, 32'h0);
        check("rst-send busy",  {31'h0, busy_o}, 32'h0);
        check("rst-send spike", bus.spike_o, 32'h0);
        check("rst-send done",  {31'h0, done_o}, 32'h0);
        bus.spike_ready_i = 1'b1;
        run("after-rst", 0, 1'b0, 1'b0);
        check("after-rst literal", exp_w[1], 32'h9494_9494);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
